// File: rtl/img_stream_pkg.sv
// Shared types and constants for the BRAM -> image-processing pixel stream.
package img_stream_pkg;

    localparam int PIX_W          = 8;
    localparam int IMG_WIDTH_DEF  = 256;
    localparam int IMG_HEIGHT_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int frame_total(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/skid_fifo.sv
// Small synchronous FIFO that holds BRAM read data while the async FIFO is full.
module skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_comb begin
        rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q + CW'(push_i) - CW'(do_pop);
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/bram_fifo_writer.sv
// Streams one frame from BRAM into the async FIFO in raster order, with
// credit-based read issue so in-flight BRAM data always has a skid slot.
module bram_fifo_writer
    import img_stream_pkg::*;
#(
    parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT   = IMG_HEIGHT_DEF,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = PIX_W,
    parameter int BRAM_LATENCY = 1
) (
    input  logic                  clk_100mhz,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int TOTAL      = frame_total(IMG_WIDTH, IMG_HEIGHT);
    localparam int SKID_DEPTH = BRAM_LATENCY + 1;
    localparam int CNT_W      = $clog2(TOTAL + 1);
    localparam int SC_W       = $clog2(SKID_DEPTH + 1);
    localparam int CR_W       = SC_W + 1;
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [BRAM_LATENCY-1:0] vld_q, vld_d;
    logic [SC_W-1:0]         skid_cnt;
    logic [DATA_WIDTH-1:0]   skid_head;
    logic [CR_W-1:0]         credit_used;
    logic                    start_ok, abort_ok, rd_ok;

    assign start_ok   = start && !abort && (state_q == IDLE);
    assign abort_ok   = abort && ((state_q == RUN) || (state_q == DRAIN));
    assign fifo_wr_en = (skid_cnt != '0) && !fifo_full;
    assign fifo_din   = fifo_wr_en ? skid_head : '0;

    // A pop this cycle frees its slot in time for a read issued now,
    // which is what sustains one pixel per clock.
    always_comb begin
        credit_used = CR_W'(skid_cnt);
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            credit_used = credit_used + CR_W'(vld_q[i]);
        end
        rd_ok = (state_q == RUN) &&
                ((credit_used - CR_W'(fifo_wr_en)) < CR_W'(SKID_DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q + CNT_W'(fifo_wr_en);
        vld_d      = vld_q << 1;
        bram_en    = 1'b0;
        bram_addr  = '0;
        busy       = (state_q == RUN) || (state_q == DRAIN);
        frame_done = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d  = RUN;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            RUN: begin
                if (rd_ok) begin
                    bram_en   = 1'b1;
                    bram_addr = ADDR_WIDTH'(rd_cnt_q);
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_C) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_cnt_d == TOTAL_C) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        vld_d[0] = bram_en;
        if (abort_ok) begin
            state_d = IDLE;
            vld_d   = '0;
        end
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            vld_q    <= vld_d;
        end
    end

    skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i   (clk_100mhz),
        .rst_ni  (reset_n),
        .clr_i   (abort_ok || start_ok),
        .push_i  (vld_q[BRAM_LATENCY-1]),
        .din_i   (bram_dout),
        .pop_i   (fifo_wr_en),
        .head_o  (skid_head),
        .count_o (skid_cnt)
    );

endmodule

// File: tb/tb_bram_fifo_writer.sv
// Scoreboard bench: two writers (BRAM latency 1 and 2) share stimulus; each has its own expected queue.
module tb_bram_fifo_writer;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int TOT = W * H;
    localparam int AW  = 8;
    localparam int DW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, start, abort, fifo_full;
    logic          bram_en    [2];
    logic [AW-1:0] bram_addr  [2];
    logic [DW-1:0] bram_dout  [2];
    logic [DW-1:0] fifo_din   [2];
    logic          fifo_wr_en [2];
    logic          busy       [2];
    logic          frame_done [2];

    bram_fifo_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_LATENCY(1)) u_dut0 (
        .clk_100mhz(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .bram_en(bram_en[0]), .bram_addr(bram_addr[0]), .bram_dout(bram_dout[0]),
        .fifo_din(fifo_din[0]), .fifo_wr_en(fifo_wr_en[0]), .fifo_full(fifo_full),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    bram_fifo_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_LATENCY(2)) u_dut1 (
        .clk_100mhz(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .bram_en(bram_en[1]), .bram_addr(bram_addr[1]), .bram_dout(bram_dout[1]),
        .fifo_din(fifo_din[1]), .fifo_wr_en(fifo_wr_en[1]), .fifo_full(fifo_full),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    // BRAM contents equal the address; latency-1 and latency-2 read ports.
    logic [DW-1:0] b1_stage = '0;
    initial begin
        bram_dout[0] = '0;
        bram_dout[1] = '0;
    end
    always @(posedge clk) begin
        if (bram_en[0]) bram_dout[0] <= bram_addr[0];
        if (bram_en[1]) b1_stage <= bram_addr[1];
        bram_dout[1] <= b1_stage;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s lat%0d: got %0d, expected %0d at %0t", nm, k + 1, act, exp, $time);
    endtask

    // Reference model: per frame phase (0 idle, 1 active, 2 done-cycle) and expected pixels.
    logic [DW-1:0] exp_q [2][$];
    int phase     [2] = '{0, 0};
    int wr_seen   [2] = '{0, 0};
    int start_cyc [2] = '{0, 0};
    int cyc = 0;
    bit timing_en = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                phase[k] = 0;
                exp_q[k].delete();
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, int'(busy[k]), int'(phase[k] == 1));
                chk("frame_done", k, int'(frame_done[k]), int'(phase[k] == 2));
                if (frame_done[k] && phase[k] == 2 && timing_en)
                    chk("frame_time", k, cyc - start_cyc[k], TOT + (k + 1) + 2);
                if (fifo_wr_en[k]) begin
                    chk("wr_while_full", k, int'(fifo_full), 0);
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_write", k, int'(fifo_din[k]), -1);
                    end else begin
                        chk("pixel", k, int'(fifo_din[k]), int'(exp_q[k].pop_front()));
                        if (wr_seen[k] == 0 && timing_en)
                            chk("first_write_latency", k, cyc - start_cyc[k], (k + 1) + 2);
                        wr_seen[k]++;
                    end
                end
                case (phase[k])
                    0: if (start && !abort) begin
                        for (int p = 0; p < TOT; p++) exp_q[k].push_back(DW'(p));
                        phase[k]     = 1;
                        wr_seen[k]   = 0;
                        start_cyc[k] = cyc;
                    end
                    1: if (abort) begin
                        exp_q[k].delete();
                        phase[k] = 0;
                    end else if (wr_seen[k] == TOT) begin
                        phase[k] = 2;
                    end
                    default: phase[k] = 0;
                endcase
            end
            if (int'(u_dut0.u_skid.count_o) > 2) chk("skid_overflow", 0, int'(u_dut0.u_skid.count_o), 2);
            if (int'(u_dut1.u_skid.count_o) > 3) chk("skid_overflow", 1, int'(u_dut1.u_skid.count_o), 3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_full);
        for (int i = 0; i < 400; i++) begin
            if (phase[0] == 0 && phase[1] == 0) begin
                fifo_full = 1'b0;
                return;
            end
            if (rand_full) fifo_full = ($urandom % 2) == 1;
            tick();
        end
        fifo_full = 1'b0;
        chk("idle_timeout", 0, 1, 0);
    endtask

    task automatic check_outputs_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_bram_en"}, k, int'(bram_en[k]), 0);
            chk({nm, "_bram_addr"}, k, int'(bram_addr[k]), 0);
            chk({nm, "_wr_en"}, k, int'(fifo_wr_en[k]), 0);
            chk({nm, "_din"}, k, int'(fifo_din[k]), 0);
            chk({nm, "_busy"}, k, int'(busy[k]), 0);
            chk({nm, "_done"}, k, int'(frame_done[k]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        fifo_full = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) tick();

        // 1: unthrottled frame with latency/frame-time checks
        timing_en = 1'b1;
        pulse_start();
        wait_idle(1'b0);
        timing_en = 1'b0;
        repeat (3) tick();

        // 2: fifo_full held for cycles 5..14 after start
        pulse_start();
        repeat (4) tick();
        fifo_full = 1'b1;
        repeat (10) tick();
        fifo_full = 1'b0;
        wait_idle(1'b0);
        repeat (2) tick();

        // 3: random backpressure over several frames
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) tick();
            pulse_start();
            wait_idle(1'b1);
        end
        repeat (2) tick();

        // 4: abort after the 7th pixel, then a fresh frame
        pulse_start();
        for (int i = 0; i < 100 && wr_seen[0] < 7; i++) tick();
        chk("abort_reached_pixel7", 0, int'(wr_seen[0] >= 7), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        pulse_start();
        wait_idle(1'b0);
        repeat (2) tick();

        // 5: start while busy, then start+abort together in IDLE
        pulse_start();
        repeat (2) tick();
        pulse_start();
        repeat (5) tick();
        pulse_start();
        wait_idle(1'b0);
        repeat (2) tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (4) tick();

        // 6: asynchronous reset mid-DRAIN
        pulse_start();
        repeat (16) tick();
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
